// File: rtl/rifl_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing the RIFL TX payload among NUM_CH valid/ready streams.
// Optional build macro RIFL_TX_ARB_PRIO_EN makes channel 0 strict priority at arbitration.
module rifl_tx_arbiter #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned PAYLOAD_WIDTH = 240,
  localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned DATA_WIDTH   = PAYLOAD_WIDTH - CH_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_CH-1:0]            s_valid,
  input  logic [NUM_CH-1:0]            s_last,
  output logic [NUM_CH-1:0]            s_ready,
  output logic [PAYLOAD_WIDTH+1:0]     rifl_tx_payload,
  input  logic                         rifl_tx_ready,
  output logic                         busy,
  output logic [CH_W-1:0]              grant_id
);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                state, state_n;
  logic [CH_W-1:0]       ptr;
  logic [CH_W-1:0]       ptr_adv;
  logic                  out_vld;
  logic                  arb_hit;
  logic [CH_W-1:0]       arb_sel;
  logic                  accept;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  can_load;
  int unsigned           ptr_i;
  int unsigned           rank;
  int unsigned           best_rank;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_ARB;
    else     state <= state_n;
  end

  // Channel selection, next state and handshake
  always_comb begin
    state_n   = state;
    s_ready   = '0;
    accept    = 1'b0;
    arb_hit   = 1'b0;
    arb_sel   = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    rank      = 0;
    best_rank = NUM_CH;
    ptr_i     = 32'(ptr);
    can_load  = ~out_vld | rifl_tx_ready;

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == grant_id) begin
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
        sel_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    // Rank each channel by its distance from ptr; the nearest valid one wins
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      rank = (i >= ptr_i) ? (i - ptr_i) : (i + NUM_CH - ptr_i);
      if (s_valid[i] && (rank < best_rank)) begin
        best_rank = rank;
        arb_sel   = CH_W'(i);
        arb_hit   = 1'b1;
      end
    end
`ifdef RIFL_TX_ARB_PRIO_EN
    if (s_valid[0]) begin
      arb_sel = '0;
      arb_hit = 1'b1;
    end
`endif

    case (state)
      ST_ARB: begin
        if (arb_hit) state_n = ST_GRANT;
      end
      ST_GRANT: begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (CH_W'(i) == grant_id) s_ready[i] = can_load;
        end
        accept = sel_valid & can_load;
        if (accept && sel_last) state_n = ST_ARB;
      end
      default: state_n = ST_ARB;
    endcase
  end

  assign ptr_adv = (grant_id == CH_W'(NUM_CH - 1)) ? '0 : grant_id + CH_W'(1);
  assign busy    = (state == ST_GRANT);

  // Grant register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id <= '0;
      ptr      <= '0;
    end else begin
      if (state == ST_ARB && arb_hit) grant_id <= arb_sel;
      if (accept && sel_last) begin
`ifdef RIFL_TX_ARB_PRIO_EN
        if (grant_id != '0) ptr <= ptr_adv;
`else
        ptr <= ptr_adv;
`endif
      end
    end
  end

  // Output payload register; drains to idle once the controller consumes it
  always_ff @(posedge clk) begin
    if (rst) begin
      rifl_tx_payload <= '0;
      out_vld         <= 1'b0;
    end else if (accept) begin
      rifl_tx_payload <= {(sel_last ? 2'b11 : 2'b01), grant_id, sel_data};
      out_vld         <= 1'b1;
    end else if (rifl_tx_ready) begin
      rifl_tx_payload <= '0;
      out_vld         <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rifl_tx_arbiter.sv
// Vector bench for rifl_tx_arbiter (NUM_CH=4, PAYLOAD_WIDTH=240); follows RIFL_TX_ARB_PRIO_EN if defined.
module tb_rifl_tx_arbiter;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned PW     = 240;
  localparam int unsigned CW     = 2;
  localparam int unsigned DW     = PW - CW;

  logic                 clk;
  logic                 rst;
  logic [NUM_CH*DW-1:0] s_data;
  logic [NUM_CH-1:0]    s_valid;
  logic [NUM_CH-1:0]    s_last;
  logic [NUM_CH-1:0]    s_ready;
  logic [PW+1:0]        rifl_tx_payload;
  logic                 rifl_tx_ready;
  logic                 busy;
  logic [CW-1:0]        grant_id;

  typedef struct {
    string      name;
    logic       r;
    logic [3:0] valid;
    logic [3:0] last;
    logic [7:0] dat;
    logic       rdy;
    logic [3:0] e_ready;
    logic [1:0] e_hdr;
    logic [1:0] e_ch;
    logic [7:0] e_dat;
    logic       e_busy;
    logic [1:0] e_gid;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  rifl_tx_arbiter #(.NUM_CH(NUM_CH), .PAYLOAD_WIDTH(PW)) dut (
    .clk             (clk),
    .rst             (rst),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_last          (s_last),
    .s_ready         (s_ready),
    .rifl_tx_payload (rifl_tx_payload),
    .rifl_tx_ready   (rifl_tx_ready),
    .busy            (busy),
    .grant_id        (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(string name, logic r, logic [3:0] valid, logic [3:0] last,
                              logic [7:0] dat, logic rdy, logic [3:0] e_ready, logic [1:0] e_hdr,
                              logic [1:0] e_ch, logic [7:0] e_dat, logic e_busy, logic [1:0] e_gid);
    vec_t v;
    v.name = name;   v.r = r;           v.valid = valid;   v.last = last;
    v.dat = dat;     v.rdy = rdy;       v.e_ready = e_ready;
    v.e_hdr = e_hdr; v.e_ch = e_ch;     v.e_dat = e_dat;
    v.e_busy = e_busy; v.e_gid = e_gid;
    return v;
  endfunction

  // Channel i carries data word {i, dat} zero-extended
  function automatic logic [PW+1:0] mk_payload(logic [1:0] hdr, logic [1:0] ch, logic [7:0] dat);
    if (hdr == 2'b00) return '0;
    return {hdr, ch, DW'({6'd0, ch, dat})};
  endfunction

  task automatic apply(input vec_t v);
    logic [PW+1:0] exp_pl;
    @(negedge clk);
    rst           = v.r;
    s_valid       = v.valid;
    s_last        = v.last;
    rifl_tx_ready = v.rdy;
    s_data = {DW'({8'd3, v.dat}), DW'({8'd2, v.dat}), DW'({8'd1, v.dat}), DW'({8'd0, v.dat})};
    #1;
    exp_pl = mk_payload(v.e_hdr, v.e_ch, v.e_dat);
    n_vec++;
    if (s_ready !== v.e_ready || rifl_tx_payload !== exp_pl || busy !== v.e_busy ||
        grant_id !== v.e_gid) begin
      n_err++;
      $display("FAIL %s: s_ready=%b want %b busy=%b want %b grant_id=%0d want %0d hdr=%b want %b ch=%0d want %0d data=%h want %h",
               v.name, s_ready, v.e_ready, busy, v.e_busy, grant_id, v.e_gid,
               rifl_tx_payload[PW+1:PW], exp_pl[PW+1:PW], rifl_tx_payload[PW-1:DW], exp_pl[PW-1:DW],
               rifl_tx_payload[15:0], exp_pl[15:0]);
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0; rifl_tx_ready = 1'b1;
    repeat (2) @(posedge clk);

    //                name       r  valid    last     dat    rdy  e_ready  hdr ch dat    busy gid
    vecs.push_back(mk("idle0",   0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("idle1",   0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("b_arb",   0, 4'b0010, 4'b0000, 8'h10, 1, 4'b0000, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("b_d0",    0, 4'b0010, 4'b0000, 8'h10, 1, 4'b0010, 0, 0, 8'h00, 1, 1));
    vecs.push_back(mk("b_d1",    0, 4'b0010, 4'b0000, 8'h11, 1, 4'b0010, 1, 1, 8'h10, 1, 1));
    vecs.push_back(mk("b_d2",    0, 4'b0010, 4'b0010, 8'h12, 1, 4'b0010, 1, 1, 8'h11, 1, 1));
    vecs.push_back(mk("b_tail",  0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 3, 1, 8'h12, 0, 1));
    vecs.push_back(mk("b_idle",  0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk("c_rst",   1, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk("c0_arb",  0, 4'b1111, 4'b0000, 8'h30, 1, 4'b0000, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("c0_b0",   0, 4'b1111, 4'b0000, 8'h31, 1, 4'b0001, 0, 0, 8'h00, 1, 0));
    vecs.push_back(mk("c0_b1",   0, 4'b1111, 4'b1111, 8'h32, 1, 4'b0001, 1, 0, 8'h31, 1, 0));
    vecs.push_back(mk("c1_arb",  0, 4'b1111, 4'b0000, 8'h33, 1, 4'b0000, 3, 0, 8'h32, 0, 0));
    vecs.push_back(mk("c1_b0",   0, 4'b1111, 4'b0000, 8'h34, 1, 4'b0010, 0, 0, 8'h00, 1, 1));
    vecs.push_back(mk("c1_b1",   0, 4'b1111, 4'b1111, 8'h35, 1, 4'b0010, 1, 1, 8'h34, 1, 1));
    vecs.push_back(mk("c2_arb",  0, 4'b1111, 4'b0000, 8'h36, 1, 4'b0000, 3, 1, 8'h35, 0, 1));
    vecs.push_back(mk("c2_b0",   0, 4'b1111, 4'b0000, 8'h37, 1, 4'b0100, 0, 0, 8'h00, 1, 2));
    vecs.push_back(mk("c2_b1",   0, 4'b1111, 4'b1111, 8'h38, 1, 4'b0100, 1, 2, 8'h37, 1, 2));
    vecs.push_back(mk("c3_arb",  0, 4'b1111, 4'b0000, 8'h39, 1, 4'b0000, 3, 2, 8'h38, 0, 2));
    vecs.push_back(mk("c3_b0",   0, 4'b1111, 4'b0000, 8'h3a, 1, 4'b1000, 0, 0, 8'h00, 1, 3));
    vecs.push_back(mk("c3_b1",   0, 4'b1111, 4'b1111, 8'h3b, 1, 4'b1000, 1, 3, 8'h3a, 1, 3));
    vecs.push_back(mk("c4_arb",  0, 4'b1111, 4'b0000, 8'h3c, 1, 4'b0000, 3, 3, 8'h3b, 0, 3));
    vecs.push_back(mk("c4_b0",   0, 4'b1111, 4'b0000, 8'h3d, 1, 4'b0001, 0, 0, 8'h00, 1, 0));
    vecs.push_back(mk("c4_b1",   0, 4'b1111, 4'b1111, 8'h3e, 1, 4'b0001, 1, 0, 8'h3d, 1, 0));
    vecs.push_back(mk("c_tail",  0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 3, 0, 8'h3e, 0, 0));
    vecs.push_back(mk("c_idle",  0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 0, 8'h00, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Backpressure: TX controller stalls five cycles with beat 0x50 pending
    apply(mk("s_arb",   0, 4'b0010, 4'b0000, 8'h50, 1, 4'b0000, 0, 0, 8'h00, 0, 0));
    apply(mk("s_d0",    0, 4'b0010, 4'b0000, 8'h50, 1, 4'b0010, 0, 0, 8'h00, 1, 1));
    for (int k = 0; k < 5; k++)
      apply(mk("s_stall", 0, 4'b0010, 4'b0000, 8'h51, 0, 4'b0000, 1, 1, 8'h50, 1, 1));
    apply(mk("s_d1",    0, 4'b0010, 4'b0000, 8'h51, 1, 4'b0010, 1, 1, 8'h50, 1, 1));
    apply(mk("s_d2",    0, 4'b0010, 4'b0010, 8'h52, 1, 4'b0010, 1, 1, 8'h51, 1, 1));
    apply(mk("s_tail",  0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 3, 1, 8'h52, 0, 1));
    apply(mk("s_idle",  0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 0, 8'h00, 0, 1));

    // Reset during beat 2 of a ch3 packet (ptr=2 beforehand); ch1 beating ch2 proves ptr=0
    apply(mk("r_arb",   0, 4'b1000, 4'b0000, 8'h60, 1, 4'b0000, 0, 0, 8'h00, 0, 1));
    apply(mk("r_d0",    0, 4'b1000, 4'b0000, 8'h60, 1, 4'b1000, 0, 0, 8'h00, 1, 3));
    apply(mk("r_d1",    1, 4'b1000, 4'b0000, 8'h61, 1, 4'b1000, 1, 3, 8'h60, 1, 3));
    apply(mk("r_after", 0, 4'b0110, 4'b0110, 8'h70, 1, 4'b0000, 0, 0, 8'h00, 0, 0));
    apply(mk("r_single",0, 4'b0110, 4'b0110, 8'h70, 1, 4'b0010, 0, 0, 8'h00, 1, 1));
    apply(mk("r_tail",  0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 3, 1, 8'h70, 0, 1));
    apply(mk("r_idle",  0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 0, 8'h00, 0, 1));

    // ch0 and ch2 contend with ptr=2
`ifdef RIFL_TX_ARB_PRIO_EN
    apply(mk("q_arb",   0, 4'b0101, 4'b0101, 8'h80, 1, 4'b0000, 0, 0, 8'h00, 0, 1));
    apply(mk("q_g0",    0, 4'b0101, 4'b0101, 8'h80, 1, 4'b0001, 0, 0, 8'h00, 1, 0));
    apply(mk("q_arb2",  0, 4'b0110, 4'b0110, 8'h81, 1, 4'b0000, 3, 0, 8'h80, 0, 0));
    apply(mk("q_g2",    0, 4'b0110, 4'b0110, 8'h81, 1, 4'b0100, 0, 0, 8'h00, 1, 2));
    apply(mk("q_tail",  0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 3, 2, 8'h81, 0, 2));
`else
    apply(mk("q_arb",   0, 4'b0101, 4'b0101, 8'h80, 1, 4'b0000, 0, 0, 8'h00, 0, 1));
    apply(mk("q_g2",    0, 4'b0101, 4'b0101, 8'h80, 1, 4'b0100, 0, 0, 8'h00, 1, 2));
    apply(mk("q_arb2",  0, 4'b0101, 4'b0101, 8'h81, 1, 4'b0000, 3, 2, 8'h80, 0, 2));
    apply(mk("q_g0",    0, 4'b0101, 4'b0101, 8'h81, 1, 4'b0001, 0, 0, 8'h00, 1, 0));
    apply(mk("q_tail",  0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 3, 0, 8'h81, 0, 0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
